// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, and registered
// single-cycle press / release / long-press events plus a debounced level.
module key_debounce #(
    parameter int CLK_HZ         = 12_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int LONG_MS        = 1000,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int LONG_CYCLES = CLK_HZ / 1000 * LONG_MS;
    localparam int CNT_W       = $clog2(LONG_CYCLES);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic             RELEASED  = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        DB_DOWN,
        DOWN,
        DOWN_LONG,
        DB_UP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             long_fired;
    logic [1:0]       sync_q;
    logic             p;

    // Synchroniser resets to the released level so a key held through reset
    // is seen as a fresh press once reset lifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{RELEASED}};
        end else begin
            sync_q <= {sync_q[0], key_in};
        end
    end

    assign p = KEY_ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

    // Debounce FSM; every state change clears cnt and pulses default low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            long_fired  <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (p) begin
                        state <= DB_DOWN;
                        cnt   <= '0;
                    end
                end
                DB_DOWN: begin
                    if (!p) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= DOWN;
                        cnt       <= '0;
                        key_press <= 1'b1;
                        key_level <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (!p) begin
                        state <= DB_UP;
                        cnt   <= '0;
                    end else if (cnt == LONG_LAST) begin
                        state      <= DOWN_LONG;
                        cnt        <= '0;
                        key_long   <= 1'b1;
                        long_fired <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DOWN_LONG: begin
                    if (!p) begin
                        state <= DB_UP;
                        cnt   <= '0;
                    end
                end
                DB_UP: begin
                    // A release bounce returns to the hold state without any event.
                    if (p) begin
                        state <= long_fired ? DOWN_LONG : DOWN;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        key_release <= 1'b1;
                        key_level   <= 1'b0;
                        long_fired  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with DB=4 and LONG=20 cycles.
module tb_key_debounce;

    logic clk;
    logic rst;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic key_long;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic       key;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    key_debounce #(
        .CLK_HZ(1000),
        .DEBOUNCE_MS(4),
        .LONG_MS(20),
        .KEY_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_in(key_in),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive key_in, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic key);
        key_in = key;
        @(posedge clk);
        #1;
    endtask

    // Compare {level, press, release, long} against the expected vector.
    task automatic checkOutput(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {key_level, key_press, key_release, key_long};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got lvl/prs/rel/lng=%b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        vec_t v;
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        key_in       = 1'b1;

        // Clean press held 12 cycles, then release; row k is checked after edge N+k.
        for (int k = 0; k < 22; k++) begin
            v.key = (k < 12) ? 1'b0 : 1'b1;
            v.exp = {(k >= 6 && k < 18), (k == 6), (k == 18), 1'b0};
            vecs.push_back(v);
        end
        // Three-cycle glitch while idle: nothing may change.
        for (int k = 0; k < 11; k++) begin
            v.key = (k < 3) ? 1'b0 : 1'b1;
            v.exp = 4'b0000;
            vecs.push_back(v);
        end

        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("reset_state", 4'b0000);
        #2 rst = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(1'b1);
        checkOutput("idle_after_reset", 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].key);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Press bounce: 5x (low 3, high 1) must give no event.
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 4; k++) begin
                applyStimulus((k < 3) ? 1'b0 : 1'b1);
                checkOutput($sformatf("bounce%0d_%0d", b, k), 4'b0000);
            end
        end
        for (int k = 0; k < 14; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("bounce_steady%0d", k), {(k >= 6), (k == 6), 2'b00});
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("bounce_rel%0d", k), {(k < 6), 1'b0, (k == 6), 1'b0});
        end

        // Long hold: press at +6, single key_long at +26.
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("long%0d", k), {(k >= 6), (k == 6), 1'b0, (k == 26)});
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("long_rel%0d", k), {(k < 6), 1'b0, (k == 6), 1'b0});
        end

        // Release bounce while in DOWN_LONG: no events, level stays high.
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("dl_hold%0d", k), {(k >= 6), (k == 6), 1'b0, (k == 26)});
        end
        for (int k = 0; k < 17; k++) begin
            applyStimulus((k < 2) ? 1'b1 : 1'b0);
            checkOutput($sformatf("dl_bounce%0d", k), 4'b1000);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("dl_rel%0d", k), {(k < 6), 1'b0, (k == 6), 1'b0});
        end

        // Reset while DOWN with the key still held.
        for (int k = 0; k < 10; k++) applyStimulus(1'b0);
        checkOutput("pre_reset_down", 4'b1000);
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", 4'b0000);
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        checkOutput("held_in_reset", 4'b0000);
        #2 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0);
            checkOutput($sformatf("post_reset%0d", k), {(k >= 6), (k == 6), 2'b00});
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1);
            checkOutput($sformatf("post_reset_rel%0d", k), {(k < 6), 1'b0, (k == 6), 1'b0});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
